// File: rtl/cook_countdown.sv
// cook_countdown: M:SS microwave cook-time down-counter, 1 Hz prescaler, done/beep.
// Optional beeper state enabled by defining COOK_BEEP_EN.
module cook_countdown #(
  parameter int TICK_DIV  = 10,
  parameter int BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] min_in,
  input  logic [2:0] sec_t_in,
  input  logic [3:0] sec_o_in,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_out,
  output logic [2:0] sec_t_out,
  output logic [3:0] sec_o_out,
  output logic       running,
  output logic       done,
  output logic       beep
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
`ifdef COOK_BEEP_EN
    ,S_BEEP
`endif
  } state_t;

  state_t state;
  logic [PW-1:0] presc;

`ifdef COOK_BEEP_EN
  localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BEEP_SECS - 1);
  logic [BW-1:0] bcnt;
`else
  wire unused_cfg = |BEEP_SECS;
`endif

  logic [3:0] ld_min;
  logic [2:0] ld_sec_t;
  logic [3:0] ld_sec_o;
  logic       nonzero;
  logic       last_sec;
  logic       tick;

  // Clamp out-of-range load digits and decode countdown conditions
  always_comb begin
    ld_min   = (min_in   > 4'd9) ? 4'd9 : min_in;
    ld_sec_t = (sec_t_in > 3'd5) ? 3'd5 : sec_t_in;
    ld_sec_o = (sec_o_in > 4'd9) ? 4'd9 : sec_o_in;
    nonzero  = (min_out != 4'd0) || (sec_t_out != 3'd0)
            || (sec_o_out != 4'd0);
    last_sec = (min_out == 4'd0) && (sec_t_out == 3'd0)
            && (sec_o_out == 4'd1);
    tick     = (presc == P_LAST);
  end

  // Control FSM, prescaler, digit chain and registered flags
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      presc     <= '0;
      min_out   <= 4'd0;
      sec_t_out <= 3'd0;
      sec_o_out <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      beep      <= 1'b0;
`ifdef COOK_BEEP_EN
      bcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_PAUSE: begin
          if (load) begin
            min_out   <= ld_min;
            sec_t_out <= ld_sec_t;
            sec_o_out <= ld_sec_o;
          end else if (!pause && start && nonzero) begin
            state   <= S_RUN;
            running <= 1'b1;
            presc   <= '0;
          end
        end
        S_RUN: begin
          if (pause) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (last_sec) begin
              sec_o_out <= 4'd0;
              done      <= 1'b1;
              running   <= 1'b0;
`ifdef COOK_BEEP_EN
              state     <= S_BEEP;
              beep      <= 1'b1;
              bcnt      <= '0;
`else
              state     <= S_IDLE;
`endif
            end else if (sec_o_out != 4'd0) begin
              sec_o_out <= sec_o_out - 4'd1;
            end else begin
              sec_o_out <= 4'd9;
              if (sec_t_out != 3'd0) begin
                sec_t_out <= sec_t_out - 3'd1;
              end else begin
                sec_t_out <= 3'd5;
                min_out   <= min_out - 4'd1;
              end
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
`ifdef COOK_BEEP_EN
        S_BEEP: begin
          if (load) begin
            min_out   <= ld_min;
            sec_t_out <= ld_sec_t;
            sec_o_out <= ld_sec_o;
            state     <= S_IDLE;
            beep      <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (bcnt == B_LAST) begin
              state <= S_IDLE;
              beep  <= 1'b0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          beep    <= 1'b0;
        end
      endcase
    end
  end

endmodule
